uart_fb_loader: RTL and testbench

//  Byte-stream protocol engine between a UART receiver/transmitter and a dual-port VGA framebuffer.

---
 rtl/vga_uart_pkg.sv | 18 +
 rtl/uart_tx_holdreg.sv | 48 ++++
 rtl/uart_fb_loader.sv | 176 +++++++++++++++++
 tb/tb_uart_fb_loader.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_uart_pkg.sv
// Shared constants and state type for the UART-to-framebuffer loader.
// Command bytes have the MSB set; response codes go back out on UART TX.
package vga_uart_pkg;

   localparam logic [7:0] CMD_SYNC    = 8'h80;
   localparam logic [7:0] CMD_SETADDR = 8'h81;
   localparam logic [7:0] CMD_ACKREQ  = 8'h82;

   localparam logic [7:0] RSP_ACK   = 8'h06;
   localparam logic [7:0] RSP_NAK   = 8'h15;
   localparam logic [7:0] RSP_FRAME = 8'h46;

   typedef enum logic [0:0] {
      S_PIX  = 1'b0,
      S_ADDR = 1'b1
   } ldr_state_t;

endpackage

// File: rtl/uart_tx_holdreg.sv
// Single-entry valid/ready holding register for response bytes.
// A push while a byte is still pending and not being accepted is dropped and flagged.
module uart_tx_holdreg (
   input  logic       clk,
   input  logic       rst,
   input  logic       push_i,
   input  logic [7:0] data_i,
   input  logic       ready_i,
   output logic       valid_o,
   output logic [7:0] data_o,
   output logic       ovf_o
);

   logic       valid_q, valid_d;
   logic [7:0] data_q, data_d;

   always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      ovf_o   = 1'b0;
      if (valid_q && ready_i) begin
         valid_d = 1'b0;
      end
      // Same-cycle accept frees the slot, so the new byte is loaded rather than dropped.
      if (push_i) begin
         if (valid_q && !ready_i) begin
            ovf_o = 1'b1;
         end else begin
            valid_d = 1'b1;
            data_d  = data_i;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q <= 1'b0;
         data_q  <= 8'h00;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
      end
   end

   assign valid_o = valid_q;
   assign data_o  = data_q;

endmodule

// File: rtl/uart_fb_loader.sv
// Decodes a UART byte stream into framebuffer pixel writes, address seeks and
// ACK/NAK/frame-complete responses. Data bytes carry 7 payload bits, MSB-first.
module uart_fb_loader
   import vga_uart_pkg::*;
#(
   parameter int H_RES    = 320,
   parameter int V_RES    = 240,
   parameter int PIXEL_W  = 12,
   parameter int ADDR_W   = $clog2(H_RES * V_RES),
   parameter int BPP      = (PIXEL_W + 6) / 7,
   parameter int ADDR_GRP = (ADDR_W + 6) / 7,
   parameter bit ACK_EN   = 1'b1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               rx_valid,
   input  logic [7:0]         rx_data,
   input  logic               rx_error,
   output logic               fb_we,
   output logic [ADDR_W-1:0]  fb_addr,
   output logic [PIXEL_W-1:0] fb_wdata,
   output logic [ADDR_W-1:0]  addr_count,
   output logic               frame_done,
   output logic               proto_err,
   output logic               tx_valid,
   output logic [7:0]         tx_data,
   input  logic               tx_ready
);

   localparam int GRP_MAX = (BPP > ADDR_GRP) ? BPP : ADDR_GRP;
   localparam int ACC_W   = 7 * GRP_MAX;
   localparam int CNT_W   = $clog2(GRP_MAX + 1);
   localparam int TOTAL   = H_RES * V_RES;

   localparam logic [CNT_W-1:0]  PIX_LAST  = CNT_W'(BPP - 1);
   localparam logic [CNT_W-1:0]  ADR_LAST  = CNT_W'(ADDR_GRP - 1);
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(TOTAL - 1);
   localparam logic [ACC_W-1:0]  TOTAL_A   = ACC_W'(TOTAL);

   ldr_state_t         state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [ACC_W-1:0]   acc_q, acc_d, new_acc;
   logic [ADDR_W-1:0]  addr_q, addr_d;
   logic               perr_q, perr_d;
   logic               we_q, we_d;
   logic [ADDR_W-1:0]  waddr_q, waddr_d;
   logic [PIXEL_W-1:0] wdata_q, wdata_d;
   logic               done_q, done_d;
   logic               err_set, err_clr;
   logic               push, ovf;
   logic [7:0]         push_data;

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      acc_d     = acc_q;
      addr_d    = addr_q;
      we_d      = 1'b0;
      waddr_d   = waddr_q;
      wdata_d   = wdata_q;
      done_d    = 1'b0;
      err_set   = 1'b0;
      err_clr   = 1'b0;
      push      = 1'b0;
      push_data = RSP_ACK;
      new_acc   = ACC_W'({acc_q, rx_data[6:0]});
      if (rx_valid) begin
         if (rx_error) begin
            state_d = S_PIX;
            cnt_d   = '0;
            acc_d   = '0;
            err_set = 1'b1;
         end else if (rx_data[7]) begin
            cnt_d = '0;
            acc_d = '0;
            // A command cutting into an address payload aborts it and is still executed.
            if (state_q == S_ADDR) begin
               state_d = S_PIX;
               err_set = 1'b1;
            end
            case (rx_data)
               CMD_SYNC: begin
                  addr_d  = '0;
                  err_clr = 1'b1;
               end
               CMD_SETADDR: state_d = S_ADDR;
               CMD_ACKREQ: begin
                  push      = 1'b1;
                  push_data = perr_q ? RSP_NAK : RSP_ACK;
               end
               default: err_set = 1'b1;
            endcase
         end else if (state_q == S_PIX) begin
            acc_d = new_acc;
            if (cnt_q == PIX_LAST) begin
               cnt_d   = '0;
               we_d    = 1'b1;
               waddr_d = addr_q;
               wdata_d = new_acc[PIXEL_W-1:0];
               if (addr_q == LAST_ADDR) begin
                  addr_d = '0;
                  done_d = 1'b1;
                  if (ACK_EN) begin
                     push      = 1'b1;
                     push_data = RSP_FRAME;
                  end
               end else begin
                  addr_d = addr_q + ADDR_W'(1);
               end
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end else begin
            acc_d = new_acc;
            if (cnt_q == ADR_LAST) begin
               cnt_d   = '0;
               state_d = S_PIX;
               if (new_acc >= TOTAL_A) begin
                  addr_d  = '0;
                  err_set = 1'b1;
               end else begin
                  addr_d = new_acc[ADDR_W-1:0];
               end
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
      end
   end

   // Set sources win over SYNC's clear so an aborted SYNC still leaves the error visible.
   assign perr_d = (err_set || ovf) ? 1'b1 : (err_clr ? 1'b0 : perr_q);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_PIX;
         cnt_q   <= '0;
         acc_q   <= '0;
         addr_q  <= '0;
         perr_q  <= 1'b0;
         we_q    <= 1'b0;
         waddr_q <= '0;
         wdata_q <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         acc_q   <= acc_d;
         addr_q  <= addr_d;
         perr_q  <= perr_d;
         we_q    <= we_d;
         waddr_q <= waddr_d;
         wdata_q <= wdata_d;
         done_q  <= done_d;
      end
   end

   uart_tx_holdreg u_txh (
      .clk     (clk),
      .rst     (rst),
      .push_i  (push),
      .data_i  (push_data),
      .ready_i (tx_ready),
      .valid_o (tx_valid),
      .data_o  (tx_data),
      .ovf_o   (ovf)
   );

   assign fb_we      = we_q;
   assign fb_addr    = waddr_q;
   assign fb_wdata   = wdata_q;
   assign addr_count = addr_q;
   assign frame_done = done_q;
   assign proto_err  = perr_q;

endmodule

// File: tb/tb_uart_fb_loader.sv
// Directed bench for uart_fb_loader at default parameters (320x240, 12-bit pixels).
module tb_uart_fb_loader;

   logic        clk;
   logic        rst;
   logic        rx_valid;
   logic [7:0]  rx_data;
   logic        rx_error;
   logic        fb_we;
   logic [16:0] fb_addr;
   logic [11:0] fb_wdata;
   logic [16:0] addr_count;
   logic        frame_done;
   logic        proto_err;
   logic        tx_valid;
   logic [7:0]  tx_data;
   logic        tx_ready;

   int n_cmp = 0;
   int n_err = 0;
   int wr_cnt = 0;
   int done_cnt = 0;

   uart_fb_loader dut (
      .clk        (clk),
      .rst        (rst),
      .rx_valid   (rx_valid),
      .rx_data    (rx_data),
      .rx_error   (rx_error),
      .fb_we      (fb_we),
      .fb_addr    (fb_addr),
      .fb_wdata   (fb_wdata),
      .addr_count (addr_count),
      .frame_done (frame_done),
      .proto_err  (proto_err),
      .tx_valid   (tx_valid),
      .tx_data    (tx_data),
      .tx_ready   (tx_ready)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(negedge clk) begin
      if (fb_we === 1'b1) wr_cnt = wr_cnt + 1;
      if (frame_done === 1'b1) done_cnt = done_cnt + 1;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp = n_cmp + 1;
      assert (obs === exp) else begin
         n_err = n_err + 1;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic send(input logic [7:0] b);
      @(negedge clk);
      rx_valid = 1'b1;
      rx_data  = b;
      @(negedge clk);
      rx_valid = 1'b0;
   endtask

   task automatic send_err(input logic [7:0] b);
      @(negedge clk);
      rx_valid = 1'b1;
      rx_error = 1'b1;
      rx_data  = b;
      @(negedge clk);
      rx_valid = 1'b0;
      rx_error = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) @(negedge clk);
   endtask

   task automatic accept();
      @(negedge clk);
      tx_ready = 1'b1;
      @(negedge clk);
      tx_ready = 1'b0;
   endtask

   initial begin
      rst      = 1'b1;
      rx_valid = 1'b0;
      rx_data  = 8'h00;
      rx_error = 1'b0;
      tx_ready = 1'b0;
      #7;
      chk("rst_we",    32'(fb_we), 32'd0);
      chk("rst_addr",  32'(fb_addr), 32'd0);
      chk("rst_wdata", 32'(fb_wdata), 32'd0);
      chk("rst_cnt",   32'(addr_count), 32'd0);
      chk("rst_done",  32'(frame_done), 32'd0);
      chk("rst_perr",  32'(proto_err), 32'd0);
      chk("rst_txv",   32'(tx_valid), 32'd0);
      chk("rst_txd",   32'(tx_data), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      idle(2);

      // 1: basic pixel
      wr_cnt = 0;
      send(8'h80);
      send(8'h12);
      chk("t1_no_early_we", 32'(fb_we), 32'd0);
      send(8'h34);
      chk("t1_we",    32'(fb_we), 32'd1);
      chk("t1_addr",  32'(fb_addr), 32'd0);
      chk("t1_wdata", 32'(fb_wdata), 32'h934);
      chk("t1_cnt",   32'(addr_count), 32'd1);
      idle(1);
      chk("t1_we_pulse", 32'(fb_we), 32'd0);
      chk("t1_nwr",   32'(wr_cnt), 32'd1);

      // 2: SYNC drops the partial pixel
      wr_cnt = 0;
      send(8'h80);
      send(8'h12);
      send(8'h80);
      send(8'h34);
      send(8'h56);
      chk("t2_addr",  32'(fb_addr), 32'd0);
      chk("t2_wdata", 32'(fb_wdata), 32'hA56);
      idle(1);
      chk("t2_nwr",   32'(wr_cnt), 32'd1);
      chk("t2_perr",  32'(proto_err), 32'd0);

      // 3: SET_ADDR then a pixel
      wr_cnt = 0;
      send(8'h81);
      send(8'h04);
      send(8'h00);
      send(8'h05);
      idle(1);
      chk("t3_seek",  32'(addr_count), 32'd65541);
      chk("t3_nwr0",  32'(wr_cnt), 32'd0);
      send(8'h01);
      send(8'h02);
      chk("t3_we",    32'(fb_we), 32'd1);
      chk("t3_addr",  32'(fb_addr), 32'd65541);
      chk("t3_wdata", 32'(fb_wdata), 32'h082);
      chk("t3_cnt",   32'(addr_count), 32'd65542);

      // 4: last pixel wraps and reports frame completion
      done_cnt = 0;
      send(8'h81);
      send(8'h04);
      send(8'h57);
      send(8'h7F);
      idle(1);
      chk("t4_seek",  32'(addr_count), 32'd76799);
      send(8'h01);
      send(8'h02);
      chk("t4_we",    32'(fb_we), 32'd1);
      chk("t4_addr",  32'(fb_addr), 32'd76799);
      chk("t4_done",  32'(frame_done), 32'd1);
      chk("t4_wrap",  32'(addr_count), 32'd0);
      chk("t4_txv",   32'(tx_valid), 32'd1);
      chk("t4_txd",   32'(tx_data), 32'h46);
      idle(1);
      chk("t4_done_pulse", 32'(frame_done), 32'd0);
      chk("t4_ndone", 32'(done_cnt), 32'd1);
      chk("t4_perr",  32'(proto_err), 32'd0);
      accept();
      chk("t4_txv_acc", 32'(tx_valid), 32'd0);

      // 5: ACK held under back-pressure, overflow, NAK, recovery
      send(8'h82);
      idle(100);
      chk("t5_hold_v", 32'(tx_valid), 32'd1);
      chk("t5_hold_d", 32'(tx_data), 32'h06);
      send(8'h82);
      chk("t5_ovf_perr", 32'(proto_err), 32'd1);
      chk("t5_ovf_d",    32'(tx_data), 32'h06);
      accept();
      chk("t5_acc_v",  32'(tx_valid), 32'd0);
      send(8'h80);
      chk("t5_sync_clr", 32'(proto_err), 32'd0);
      send(8'h85);
      chk("t5_bad_cmd", 32'(proto_err), 32'd1);
      send(8'h82);
      chk("t5_nak_v",  32'(tx_valid), 32'd1);
      chk("t5_nak_d",  32'(tx_data), 32'h15);
      accept();
      send(8'h80);
      send(8'h82);
      chk("t5_ack_d",  32'(tx_data), 32'h06);
      chk("t5_ack_perr", 32'(proto_err), 32'd0);
      @(negedge clk);
      tx_ready = 1'b1;
      rx_valid = 1'b1;
      rx_data  = 8'h82;
      @(negedge clk);
      tx_ready = 1'b0;
      rx_valid = 1'b0;
      chk("t5_same_v",    32'(tx_valid), 32'd1);
      chk("t5_same_perr", 32'(proto_err), 32'd0);
      accept();
      chk("t5_final_v", 32'(tx_valid), 32'd0);

      // rx_error drops the partial pixel; out-of-range seek
      wr_cnt = 0;
      send(8'h80);
      send(8'h12);
      send_err(8'h34);
      chk("e_perr", 32'(proto_err), 32'd1);
      send(8'h34);
      send(8'h56);
      chk("e_addr",  32'(fb_addr), 32'd0);
      chk("e_wdata", 32'(fb_wdata), 32'hA56);
      idle(1);
      chk("e_nwr",   32'(wr_cnt), 32'd1);
      send(8'h80);
      send(8'h81);
      send(8'h04);
      send(8'h58);
      send(8'h00);
      chk("oor_cnt",  32'(addr_count), 32'd0);
      chk("oor_perr", 32'(proto_err), 32'd1);

      // 6: asynchronous reset mid-pixel
      send(8'h80);
      send(8'h81);
      send(8'h00);
      send(8'h00);
      send(8'h05);
      send(8'h85);
      send(8'h82);
      send(8'h12);
      chk("t6_pre_cnt", 32'(addr_count), 32'd5);
      #2 rst = 1'b1;
      #1;
      chk("t6_cnt",  32'(addr_count), 32'd0);
      chk("t6_perr", 32'(proto_err), 32'd0);
      chk("t6_txv",  32'(tx_valid), 32'd0);
      chk("t6_txd",  32'(tx_data), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      wr_cnt = 0;
      send(8'h34);
      send(8'h56);
      chk("t6_we",    32'(fb_we), 32'd1);
      chk("t6_addr",  32'(fb_addr), 32'd0);
      chk("t6_wdata", 32'(fb_wdata), 32'hA56);
      idle(1);
      chk("t6_nwr",   32'(wr_cnt), 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
